// File: rtl/bcd_7seg_scan.sv
// Multiplexed N-digit BCD to 7-segment scan driver.
// Shadow-registered value, one-hot digit scan, leading-zero blanking, polarity select.
module bcd_7seg_scan #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 1000,
    parameter int ACTIVE_LOW  = 0,
    parameter int LZ_SUPPRESS = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    blank,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);
    localparam logic INV = (ACTIVE_LOW != 0);
    localparam logic LZ  = (LZ_SUPPRESS != 0);

    logic [PW-1:0]           presc;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] bcd_sh;
    logic [NUM_DIGITS-1:0]   dp_sh;
    logic                    tc;
    logic                    wrap;

    logic [3:0]            cur_code;
    logic                  cur_dp;
    logic                  cur_sup;
    logic [NUM_DIGITS-1:0] cur_an;
    logic [NUM_DIGITS-1:0] sup;
    logic                  zrun;
    logic [6:0]            seg_nx;

    assign tc   = (presc == P_LAST);
    assign wrap = tc && (idx == I_LAST);

    function automatic logic [6:0] decode(input logic [3:0] c);
        logic [6:0] s;
        case (c)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    // Suppression chain from the top digit down, then pick the scanned digit.
    always_comb begin
        sup      = '0;
        zrun     = 1'b1;
        cur_code = 4'd0;
        cur_dp   = 1'b0;
        cur_sup  = 1'b0;
        cur_an   = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zrun   = zrun && (bcd_sh[4*i +: 4] == 4'd0);
            sup[i] = zrun;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_code  = bcd_sh[4*i +: 4];
                cur_dp    = dp_sh[i];
                cur_sup   = sup[i];
                cur_an[i] = 1'b1;
            end
        end
        seg_nx = (LZ && cur_sup) ? 7'h00 : decode(cur_code);
    end

    // Prescaler, digit index and end-of-frame pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc      <= '0;
            idx        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= wrap;
            if (tc) begin
                presc <= '0;
                idx   <= wrap ? '0 : idx + IW'(1);
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

    // Shadow capture; the scan position is untouched by loads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd_sh <= '0;
            dp_sh  <= '0;
        end else if (load) begin
            bcd_sh <= bcd_in;
            dp_sh  <= dp_in;
        end
    end

    // Registered display outputs with blanking and polarity applied last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= {7{INV}};
            dp  <= INV;
            an  <= {NUM_DIGITS{INV}};
        end else if (blank) begin
            seg <= {7{INV}};
            dp  <= INV;
            an  <= {NUM_DIGITS{INV}};
        end else begin
            seg <= seg_nx ^ {7{INV}};
            dp  <= cur_dp ^ INV;
            an  <= cur_an ^ {NUM_DIGITS{INV}};
        end
    end

endmodule

// File: doc/bcd_7seg_scan.md
Name: bcd_7seg_scan

Overview:
Multiplexed N-digit BCD-to-7-segment display driver. It is the parametrised successor to the single-digit combinational decoder. It captures a packed BCD word into a shadow register, time-multiplexes one digit at a time onto shared segment lines with one-hot digit enables, and adds leading-zero suppression, decimal points, blanking, invalid-code flagging and selectable output polarity. It sits between display-value producers (counters, measurement blocks) and the board's common-anode or common-cathode display.

Parameters:
NUM_DIGITS, 4, number of digits scanned; legal range 1..8.
REFRESH_DIV, 1000, clock cycles each digit is held; must be >= 1.
ACTIVE_LOW, 0, 1 inverts seg, dp and an at the output registers.
LZ_SUPPRESS, 1, 1 enables leading-zero blanking.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
bcd_in  in  4*NUM_DIGITS  packed BCD value; digit i at bits [4i+3:4i], digit 0 least significant
dp_in  in  NUM_DIGITS  decimal point request per digit
load  in  1  capture bcd_in/dp_in into shadow registers
blank  in  1  force display dark while high
seg  out  7  segments {g,f,e,d,c,b,a} = seg[6:0]
dp  out  1  decimal point segment
an  out  NUM_DIGITS  one-hot digit enable
frame_done  out  1  single-cycle pulse when the scan wraps from last digit to digit 0

Behaviour:
- Reset (async, active-high): prescaler=0, digit index=0, shadow bcd/dp=0, frame_done=0. seg/dp/an are forced to inactive levels: all 0 when ACTIVE_LOW=0, all 1 when ACTIVE_LOW=1. Deassertion takes effect at the next clk edge.
- Prescaler counts 0..REFRESH_DIV-1. When it reaches terminal count:
  - it returns to 0;
  - the index advances;
  - the index wraps from NUM_DIGITS-1 to 0.
- With REFRESH_DIV=1 the index advances every cycle.
- frame_done is registered. It is high for exactly the cycle after the edge where the index wraps to 0. For NUM_DIGITS=1 it pulses on every terminal count.
- load=1 at an edge copies bcd_in/dp_in into the shadow registers. A load does not disturb the prescaler or the index. Inputs are ignored while load=0.
- Outputs are registered from the current index and shadow, giving 1-cycle latency.
  - After an index change at edge k, the new digit appears after edge k+1.
  - After a load at edge k, the new value appears after edge k+1.
- Decode (active-high form, hex on seg[6:0]):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Codes 10..15 are invalid and show a dash, 40 (segment g only).
- Leading-zero suppression (LZ_SUPPRESS=1):
  - Digit i (i>0) is suppressed when its code is 0 and every higher digit's code is also 0.
  - Digit 0 is never suppressed.
  - An invalid code is non-zero, so it stops suppression below it.
  - A suppressed digit drives seg=00, but dp still follows dp_in[i] and an still selects the digit.
- an = one-hot of index (bit i set for digit i). dp = shadow dp[index].
- blank=1 at an edge: seg/dp/an go inactive after that edge. Prescaler and index keep running. Display resumes with the current index after the first edge where blank=0.
- ACTIVE_LOW inverts seg, dp and an after all of the above, including reset and blank levels.
- Simultaneous load and index advance at the same edge: both take effect. The next output update shows the new index with the new shadow data.
- Reset mid-scan: returns immediately to the reset state. The shadow value is lost.

Test Plan:
1. Bench setup for all scenarios: NUM_DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=0, LZ_SUPPRESS=1.
2. Reset, then load bcd_in=16'h1234 -> an cycles 0001,0010,0100,1000, each held 4 cycles; seg=66,4F,5B,06 respectively. frame_done pulses once per 16 cycles, the cycle after the 1000->0001 wrap.
3. Digit sweep: sweep digit 0 through 0..15 with upper digits 0 -> digit 0 seg matches the decode table, with 40 for codes 10..15. Digits 1..3 show seg=00 (suppressed). Load 16'h0A05 -> digit 3 shows 00, digit 2 shows 40, digit 1 shows 3F (not suppressed), digit 0 shows 6D.
4. Decimal point and blanking: load 16'h0000 with dp_in=4'b0100 -> digit 0 shows 3F; digits 1 and 3 show 00 with dp=0; digit 2 shows 00 with dp=1. Assert blank for 10 cycles -> seg/dp/an=0 during that window, and an resumes at the index the prescaler has reached.
5. ACTIVE_LOW=1 rerun of scenario 2 -> all outputs bitwise inverted (digit 0: seg=19, an=1110). During reset, seg=7F, dp=1, an=1111.
6. Reset and pipeline checks: assert rst mid-digit-2 -> outputs go inactive asynchronously, and after release the scan restarts at digit 0 with shadow 0 (seg=3F). Assert load at the same edge as an index advance -> the new value appears on the new digit exactly 1 cycle later. REFRESH_DIV=1 -> an changes every cycle.
